// File: rtl/add24_result_acc.sv
// -----------------------------------------------------------------------------
// add24_result_acc
//
// Purpose:
//   Sums batches of unsigned results coming from an upstream WIDTH-bit adder.
//   Each accepted result ({carry, sum}, WIDTH+1 bits) is zero-extended and
//   added into an accumulator wide enough that a full batch cannot overflow.
//   A batch closes either when BATCH results have been accepted or when the
//   upstream asks for an early close with i_flush. The closed batch is then
//   presented downstream and held until it is taken.
//
// Parameters:
//   WIDTH   operand width of the upstream adder (results are WIDTH+1 bits)
//   BATCH   results per full batch, legal range 2..256
//   ACC_W   derived: WIDTH+1+$clog2(BATCH), batch sum width
//   CNT_W   derived: $clog2(BATCH+1), result count width
//
// Ports:
//   i_clk     sole clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_valid   upstream result valid
//   o_ready   block accepts a result this cycle (high while collecting)
//   i_result  unsigned adder result {carry, sum}
//   i_flush   close the current batch early (ignored for an empty batch)
//   o_valid   batch sum available
//   i_ready   downstream takes the batch sum
//   o_sum     sum of the results in the presented batch
//   o_count   number of results in o_sum
//   o_max     largest result in the presented batch (only with the macro)
//
// Configuration:
//   ADD24_ACC_MAX_EN  when defined, adds o_max and the max-tracking logic.
// -----------------------------------------------------------------------------
module add24_result_acc #(
    parameter  int WIDTH = 24,
    parameter  int BATCH = 8,
    localparam int ACC_W = WIDTH + 1 + $clog2(BATCH),
    localparam int CNT_W = $clog2(BATCH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH:0]   i_result,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
`ifdef ADD24_ACC_MAX_EN
    output logic [WIDTH:0]   o_max,
`endif
    output logic [CNT_W-1:0] o_count
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,   // collecting results
        ST_DONE  = 1'b1    // holding a closed batch for downstream
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ACC_W-1:0]  r_acc;      // running sum of the open batch
    logic [CNT_W-1:0]  r_cnt;      // results in the open batch
    logic [ACC_W-1:0]  r_sum;      // presented batch sum
    logic [CNT_W-1:0]  r_count;    // presented batch count

    // -------------------------------------------------------------------------
    // Beat qualification
    // -------------------------------------------------------------------------
    logic              w_accept;   // a result is consumed this cycle
    logic [WIDTH:0]    w_beat;     // result gated by w_accept
    logic [ACC_W-1:0]  w_acc_sum;  // accumulator including this cycle's beat
    logic [CNT_W-1:0]  w_cnt_sum;  // count including this cycle's beat
    logic              w_close;    // batch closes at this edge
    logic              w_release;  // downstream takes the batch at this edge
    logic              w_ready;
    logic              w_valid;

    assign w_accept  = (r_state == ST_ACCUM) && i_valid;

    // i_result is forced to zero when not accepted so an undriven or X value
    // on an idle input bus never reaches the accumulator or the max tracker.
    assign w_beat    = w_accept ? i_result : '0;
    assign w_acc_sum = r_acc + {{(ACC_W - WIDTH - 1){1'b0}}, w_beat};
    assign w_cnt_sum = r_cnt + {{(CNT_W - 1){1'b0}}, w_accept};

`ifdef ADD24_ACC_MAX_EN
    logic [WIDTH:0]    r_max_acc;  // largest result in the open batch
    logic [WIDTH:0]    r_max;      // presented batch maximum
    logic [WIDTH:0]    w_max_sum;  // running max including this cycle's beat

    assign w_max_sum = (w_accept && (w_beat > r_max_acc)) ? w_beat : r_max_acc;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        w_close      = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                w_ready = 1'b1;
                // Full batch wins; otherwise a flush closes the batch only if
                // it would contain at least one result (the beat arriving now
                // counts), so an empty batch is never emitted.
                if (w_accept && (w_cnt_sum == CNT_W'(BATCH))) begin
                    w_close = 1'b1;
                end else if (i_flush && (w_accept || (r_cnt != '0))) begin
                    w_close = 1'b1;
                end
                if (w_close) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // Inputs (i_valid, i_flush) are not looked at here; w_accept is
                // already low because it is qualified by ST_ACCUM.
                w_valid = 1'b1;
                if (i_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_ACCUM;
                end
            end

            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: accumulator, counter and presented batch registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else begin
            // The running accumulator keeps its final value while the batch is
            // held and is cleared on the downstream handshake, which starts the
            // next batch. No beat can be accepted in that cycle.
            if (w_release) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_sum;
                r_cnt <= w_cnt_sum;
            end

            // The presented values load from the sums that include the beat
            // of the closing cycle, so a flush together with a beat counts it.
            if (w_close) begin
                r_sum   <= w_acc_sum;
                r_count <= w_cnt_sum;
            end
        end
    end

`ifdef ADD24_ACC_MAX_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_max_acc <= '0;
            r_max     <= '0;
        end else begin
            if (w_release) begin
                r_max_acc <= '0;
            end else if (w_accept) begin
                r_max_acc <= w_max_sum;
            end

            if (w_close) begin
                r_max <= w_max_sum;
            end
        end
    end

    assign o_max = r_max;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_ready = w_ready;
    assign o_valid = w_valid;
    assign o_sum   = r_sum;
    assign o_count = r_count;

endmodule

// File: tb/tb_add24_result_acc.sv
module tb_add24_result_acc;

    localparam int WIDTH = 24;
    localparam int BATCH = 8;
    localparam int ACC_W = WIDTH + 1 + $clog2(BATCH);
    localparam int CNT_W = $clog2(BATCH + 1);

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH:0]   i_result;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [ACC_W-1:0] o_sum;
    logic [CNT_W-1:0] o_count;
`ifdef ADD24_ACC_MAX_EN
    logic [WIDTH:0]   o_max;
`endif

    int n_cmp = 0;
    int n_err = 0;

    add24_result_acc #(
        .WIDTH (WIDTH),
        .BATCH (BATCH)
    ) u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_result (i_result),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
`ifdef ADD24_ACC_MAX_EN
        .o_max    (o_max),
`endif
        .o_count  (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one result for exactly one edge.
    task automatic beat(input logic [WIDTH:0] v, input logic flush);
        i_valid  = 1'b1;
        i_result = v;
        i_flush  = flush;
        step();
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        i_result = '0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic r,
                             input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c);
        check_val({tag, ".o_valid"}, 64'(o_valid), 64'(v));
        check_val({tag, ".o_ready"}, 64'(o_ready), 64'(r));
        check_val({tag, ".o_sum"},   64'(o_sum),   64'(s));
        check_val({tag, ".o_count"}, 64'(o_count), 64'(c));
    endtask

    // Take the presented batch with a one-cycle handshake.
    task automatic take();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_result = '0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;

        // ---- reset state ------------------------------------------------
        step();
        step();
        check_out("rst", 1'b0, 1'b1, '0, '0);
        i_rst_n = 1'b1;
        step();
        check_out("rst_rel", 1'b0, 1'b1, '0, '0);

        // ---- eight back-to-back max results, i_ready high --------------
        i_ready = 1'b1;
        for (int i = 0; i < BATCH; i++) begin
            check_val($sformatf("full.ready%0d", i), 64'(o_ready), 64'd1);
            beat(25'h1FFFFFF, 1'b0);
        end
        check_out("full", 1'b1, 1'b0, 28'hFFFFFF8, 4'd8);
        step();   // handshake with i_ready still high
        i_ready = 1'b0;
        check_out("full_taken", 1'b0, 1'b1, 28'hFFFFFF8, 4'd8);

        // ---- backpressure: hold the batch for 5 cycles ------------------
        for (int i = 0; i < BATCH; i++) beat(25'd3, 1'b0);
        i_valid  = 1'b1;
        i_result = 25'd100;
        i_flush  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("hold%0d", i), 1'b1, 1'b0, 28'd24, 4'd8);
            step();
        end
        check_out("hold5", 1'b1, 1'b0, 28'd24, 4'd8);
        // Handshake with a beat still offered: that beat must not be taken.
        i_flush = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        i_valid = 1'b0;
        check_out("hold_taken", 1'b0, 1'b1, 28'd24, 4'd8);

        // ---- flush without a beat --------------------------------------
        beat(25'd1, 1'b0);
        beat(25'd2, 1'b0);
        beat(25'd3, 1'b0);
        check_out("pre_flush", 1'b0, 1'b1, 28'd24, 4'd8);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check_out("flush3", 1'b1, 1'b0, 28'd6, 4'd3);
        take();
        check_out("flush3_taken", 1'b0, 1'b1, 28'd6, 4'd3);

        // ---- flush together with the 4th beat ---------------------------
        beat(25'd1, 1'b0);
        beat(25'd2, 1'b0);
        beat(25'd3, 1'b0);
        beat(25'd4, 1'b1);
        check_out("flush4", 1'b1, 1'b0, 28'd10, 4'd4);
        take();

        // ---- flush on an empty batch is ignored -------------------------
        i_flush  = 1'b1;
        i_result = 'x;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("empty%0d.o_valid", i), 64'(o_valid), 64'd0);
            check_val($sformatf("empty%0d.o_ready", i), 64'(o_ready), 64'd1);
        end
        i_flush  = 1'b0;
        i_result = '0;

        // ---- reset mid-batch discards partial results -------------------
        for (int i = 0; i < 5; i++) beat(25'd9, 1'b0);
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check_out("mid_rst", 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < BATCH; i++) beat(25'd1, 1'b0);
        check_out("after_rst", 1'b1, 1'b0, 28'd8, 4'd8);

        // ---- reset while holding a batch --------------------------------
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check_out("done_rst", 1'b0, 1'b1, '0, '0);

`ifdef ADD24_ACC_MAX_EN
        // ---- maximum tracking -------------------------------------------
        beat(25'd5, 1'b0);
        beat(25'h1000000, 1'b0);
        beat(25'd7, 1'b1);
        check_out("max1", 1'b1, 1'b0, 28'h100000C, 4'd3);
        check_val("max1.o_max", 64'(o_max), 64'h1000000);
        take();
        beat(25'd1, 1'b0);
        beat(25'd2, 1'b1);
        check_out("max2", 1'b1, 1'b0, 28'd3, 4'd2);
        check_val("max2.o_max", 64'(o_max), 64'd2);
        take();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add24_result_acc.md
ADD24_RESULT_ACC -- requirements
Module: add24_result_acc

Interface
REQ-001 Parameter WIDTH, default 24: operand width of the upstream 24-bit adder; results are WIDTH+1 bits.
REQ-002 Parameter BATCH, default 8, legal 2..256: number of adder results summed per output batch.
REQ-003 Derived ACC_W = WIDTH+1+$clog2(BATCH); derived CNT_W = $clog2(BATCH+1).
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  synchronous, active-low reset.
REQ-006 i_valid  input  1  upstream result valid.
REQ-007 o_ready  output  1  block can accept a result this cycle.
REQ-008 i_result  input  WIDTH+1  unsigned adder result {carry, sum}.
REQ-009 i_flush  input  1  close current batch early.
REQ-010 o_valid  output  1  batch sum available.
REQ-011 i_ready  input  1  downstream accepts batch sum.
REQ-012 o_sum  output  ACC_W  unsigned sum of the accepted results in the batch.
REQ-013 o_count  output  CNT_W  number of results contained in o_sum.

Function
REQ-014 FSM SHALL have two states: ACCUM (collecting) and DONE (holding output).
REQ-015 ACCUM: o_ready=1, o_valid=0; beat accepted when i_valid&&o_ready; on accept acc<=acc+i_result (zero-extended to ACC_W, never overflows), cnt<=cnt+1.
REQ-016 ACCUM -> DONE on the accept that makes cnt equal BATCH; o_sum/o_count load the final values; o_valid=1 on the following cycle (latency 1 from last accept).
REQ-017 i_flush in ACCUM with cnt>0 and no accept SHALL go to DONE with the partial sum/count.
REQ-018 i_flush in the same cycle as an accept SHALL include that beat, then go to DONE.
REQ-019 i_flush with cnt==0 and no accept SHALL be ignored (no empty batch emitted).
REQ-020 DONE: o_ready=0, o_valid=1; o_sum, o_count (and o_max if present) SHALL be held stable until o_valid&&i_ready.
REQ-021 On o_valid&&i_ready: next cycle o_valid=0, acc=0, cnt=0, state ACCUM; no input beat is accepted in the handshake cycle.
REQ-022 i_flush in DONE SHALL be ignored; i_valid in DONE SHALL be ignored (input not consumed).
REQ-023 Minimum period per full batch: BATCH+1 cycles with i_ready held high.
REQ-024 Inputs i_result/i_flush SHALL be sampled only when the conditions above qualify them; X on unqualified inputs SHALL not propagate.

Reset
REQ-025 i_rst_n low at a rising edge SHALL force state ACCUM, acc=0, cnt=0, o_valid=0, o_sum=0, o_count=0 (o_max=0 if present); o_ready=1 from the first cycle after reset release.
REQ-026 Reset mid-batch or in DONE SHALL discard partial/pending results without emitting them.

Configuration
REQ-027 Macro ADD24_ACC_MAX_EN defined: port o_max output WIDTH+1 SHALL exist, track the maximum i_result accepted in the batch, load and hold with o_sum, clear to 0 at batch start.
REQ-028 ADD24_ACC_MAX_EN undefined: no o_max port, no max-tracking logic; all other behaviour identical.

Verification
REQ-029 BATCH=8, eight back-to-back beats of 25'h1FFFFFF, i_ready=1 -> o_valid one cycle after 8th accept, o_sum=28'hFFFFFF8, o_count=8, o_ready=0 that cycle.
REQ-030 Full batch complete, i_ready=0 for 5 cycles while i_valid=1 -> o_valid, o_sum, o_count stable, o_ready=0, no input consumed; i_ready=1 -> o_valid=0 next cycle, o_ready=1.
REQ-031 Beats 1, 2, 3 then i_flush (no i_valid) -> o_sum=6, o_count=3; flush asserted together with 4th beat value 4 -> o_sum=10, o_count=4.
REQ-032 i_flush with cnt=0 for 3 cycles -> o_valid stays 0, o_ready stays 1.
REQ-033 Reset pulse after 5 of 8 beats, then 8 beats of 1 -> o_sum=8, o_count=8 (earlier beats discarded).
REQ-034 With ADD24_ACC_MAX_EN, beats 5, 25'h1000000, 7 then flush -> o_max=25'h1000000, o_sum=25'h100000C, o_count=3; next batch of 1, 2 with flush -> o_max=2.
